alu_8bit: RTL and testbench



---
 rtl/alu_8bit.sv | 93 +++++++++
 tb/tb_alu_8bit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: sixteen opcode-selected functions of A and B with a
// one-cycle result latency and an add-carry flag that ignores the opcode.
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_Out,
    output logic       CarryOut
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    // Division by zero saturates to all ones rather than producing X.
    function automatic logic [7:0] safe_div(input logic [7:0] num, input logic [7:0] den);
        logic [7:0] q;
        if (den == 8'h00) begin
            q = 8'hFF;
        end else begin
            q = num / den;
        end
        return q;
    endfunction

    function automatic logic [7:0] flag_byte(input logic cond);
        return cond ? 8'h01 : 8'h00;
    endfunction

    logic [8:0] sum_s;
    logic [7:0] result_s;
    logic [7:0] alu_out_r;
    logic       carry_out_r;

    // Nine-bit sum supplies both the add result and the carry flag.
    always_comb begin
        sum_s = {1'b0, A} + {1'b0, B};
    end

    // Next-result selection; every opcode value is decoded explicitly.
    always_comb begin
        result_s = 8'h00;
        case (ALU_Sel)
            OP_ADD:  result_s = sum_s[7:0];
            OP_SUB:  result_s = A - B;
            OP_MUL:  result_s = A * B;
            OP_DIV:  result_s = safe_div(A, B);
            OP_SHL:  result_s = {A[6:0], 1'b0};
            OP_SHR:  result_s = {1'b0, A[7:1]};
            OP_ROL:  result_s = {A[6:0], A[7]};
            OP_ROR:  result_s = {A[0], A[7:1]};
            OP_AND:  result_s = A & B;
            OP_OR:   result_s = A | B;
            OP_XOR:  result_s = A ^ B;
            OP_NOR:  result_s = ~(A | B);
            OP_NAND: result_s = ~(A & B);
            OP_XNOR: result_s = ~(A ^ B);
            OP_GT:   result_s = flag_byte(A > B);
            OP_EQ:   result_s = flag_byte(A == B);
            default: result_s = 8'h00;
        endcase
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out_r   <= 8'h00;
            carry_out_r <= 1'b0;
        end else begin
            alu_out_r   <= result_s;
            carry_out_r <= sum_s[8];
        end
    end

    assign ALU_Out  = alu_out_r;
    assign CarryOut = carry_out_r;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] alu_out;
    logic       carry_out;

    int total = 0;
    int bad   = 0;

    alu_8bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (a),
        .B        (b),
        .ALU_Sel  (sel),
        .ALU_Out  (alu_out),
        .CarryOut (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result computed with integer arithmetic from the opcode table.
    function automatic int ref_result(input int x, input int y, input int op);
        int r;
        case (op)
            0:  r = (x + y) % 256;
            1:  r = (x - y + 256) % 256;
            2:  r = (x * y) % 256;
            3:  r = (y == 0) ? 255 : x / y;
            4:  r = (x * 2) % 256;
            5:  r = x / 2;
            6:  r = (x * 2) % 256 + x / 128;
            7:  r = x / 2 + (x % 2) * 128;
            8:  r = x & y;
            9:  r = x | y;
            10: r = x ^ y;
            11: r = 255 - (x | y);
            12: r = 255 - (x & y);
            13: r = 255 - (x ^ y);
            14: r = (x > y) ? 1 : 0;
            15: r = (x == y) ? 1 : 0;
            default: r = 0;
        endcase
        return r;
    endfunction

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] sv);
        @(negedge clk);
        a = av;
        b = bv;
        sel = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        apply(8'hFF, 8'hFF, 4'h0);
        apply(8'hFF, 8'hFF, 4'h0);
        total++;
        if (alu_out !== 8'h00 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL reset: got out=%h c=%b want out=00 c=0", alu_out, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (alu_out !== 8'hFE || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got out=%h c=%b want out=fe c=1", alu_out, carry_out);
        end
    endtask

    task automatic test_opcode_sweep;
        logic [7:0] exp_tbl [16];
        exp_tbl = '{8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05, 8'h02,
                    8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00, 8'h0C};
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            op = 4'((i + 1) % 16);
            apply(8'h0A, 8'h02, op);
            total++;
            if (alu_out !== exp_tbl[i] || carry_out !== 1'b0) begin
                bad++;
                $display("FAIL sweep op=%h: got out=%h c=%b want out=%h c=0",
                         op, alu_out, carry_out, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_carry;
        apply(8'hF6, 8'h0A, 4'h0);
        total++;
        if (alu_out !== 8'h00 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL carry_add: got out=%h c=%b want out=00 c=1", alu_out, carry_out);
        end
        apply(8'hF6, 8'h0A, 4'h8);
        total++;
        if (alu_out !== 8'h02 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL carry_and: got out=%h c=%b want out=02 c=1", alu_out, carry_out);
        end
    endtask

    task automatic test_edge_arith;
        apply(8'h02, 8'h0A, 4'h1);
        total++;
        if (alu_out !== 8'hF8) begin
            bad++;
            $display("FAIL sub_wrap: got %h want f8", alu_out);
        end
        apply(8'h10, 8'h20, 4'h2);
        total++;
        if (alu_out !== 8'h00) begin
            bad++;
            $display("FAIL mul_trunc: got %h want 00", alu_out);
        end
        apply(8'h37, 8'h00, 4'h3);
        total++;
        if (alu_out !== 8'hFF) begin
            bad++;
            $display("FAIL div_zero: got %h want ff", alu_out);
        end
    endtask

    task automatic test_shift_rotate;
        logic [7:0] exp_tbl [4];
        exp_tbl = '{8'h02, 8'h40, 8'h03, 8'hC0};
        for (int i = 0; i < 4; i++) begin
            logic [3:0] op;
            op = 4'(4 + i);
            apply(8'h81, 8'($urandom_range(0, 255)), op);
            total++;
            if (alu_out !== exp_tbl[i]) begin
                bad++;
                $display("FAIL shift op=%h: got %h want %h", op, alu_out, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_compare_latency;
        apply(8'h5A, 8'h5A, 4'hF);
        total++;
        if (alu_out !== 8'h01) begin
            bad++;
            $display("FAIL eq: got %h want 01", alu_out);
        end
        apply(8'h5A, 8'h5A, 4'hE);
        total++;
        if (alu_out !== 8'h00) begin
            bad++;
            $display("FAIL gt_equal: got %h want 00", alu_out);
        end
        a = 8'hFF;
        b = 8'h01;
        sel = 4'h0;
        #3;
        total++;
        if (alu_out !== 8'h00 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL hold: got out=%h c=%b want out=00 c=0", alu_out, carry_out);
        end
        @(posedge clk);
        #1;
        total++;
        if (alu_out !== 8'h00 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL hold_update: got out=%h c=%b want out=00 c=1", alu_out, carry_out);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++) begin
            int x, y, op, exp_r;
            logic exp_c, rst_bit;
            x  = int'($urandom_range(0, 255));
            y  = (n % 10 == 0) ? 0 : int'($urandom_range(0, 255));
            op = int'($urandom_range(0, 15));
            rst_bit = ($urandom_range(0, 15) != 0);
            @(negedge clk);
            rst_n = rst_bit;
            a = 8'(x);
            b = 8'(y);
            sel = 4'(op);
            @(posedge clk);
            #1;
            exp_r = rst_bit ? ref_result(x, y, op) : 0;
            exp_c = rst_bit ? ((x + y) >= 256) : 1'b0;
            total++;
            if (alu_out !== 8'(exp_r) || carry_out !== exp_c) begin
                bad++;
                $display("FAIL random a=%h b=%h op=%h rst_n=%b: got out=%h c=%b want out=%h c=%b",
                         8'(x), 8'(y), 4'(op), rst_bit, alu_out, carry_out, 8'(exp_r), exp_c);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 16; n++) begin
            int x, y;
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(1, 255));
            apply(8'(x), 8'(y), 4'(n));
            total++;
            if (alu_out !== 8'(ref_result(x, y, n)) || carry_out !== ((x + y) >= 256)) begin
                bad++;
                $display("FAIL b2b op=%h: got out=%h c=%b want out=%h",
                         4'(n), alu_out, carry_out, 8'(ref_result(x, y, n)));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a = 8'h00;
        b = 8'h00;
        sel = 4'h0;
        test_reset();
        test_opcode_sweep();
        test_carry();
        test_edge_arith();
        test_shift_rotate();
        test_compare_latency();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
